// File: rtl/cpu_pipe_pkg.sv
// Shared types for the CPU pipeline stage registers: handshake FSM states,
// occupancy width and the per-stage payload layouts.
package cpu_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   localparam int OCC_W = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_wr;
   } mem_wb_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot: data register plus valid flag. Clearing the valid flag
// leaves the data untouched so a squashed slot still shows its last payload.
module pipe_entry_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         if (load_i)
            data_q <= d_i;
         // Clear wins so a squash can never leave a freshly loaded slot valid.
         if (clr_i)
            valid_q <= 1'b0;
         else if (load_i)
            valid_q <= 1'b1;
      end
   end

   assign q_o     = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, synchronous flush and an
// optional second (skid) slot that makes in_ready a pure register output.
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   pipe_state_e      state_q, state_d;
   logic             accept, drain;
   logic             main_load, main_clr, skid_load, skid_clr;
   logic [WIDTH-1:0] main_d, main_q, skid_q;
   logic             main_valid, skid_valid;

   always_comb begin
      accept    = in_valid & in_ready;
      drain     = main_valid & out_ready;
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      main_d    = in_data;
      state_d   = state_q;
      case (state_q)
         EMPTY: if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
         end
         ONE: if (accept && drain) begin
            main_load = 1'b1;
         end else if (accept && SKID) begin
            skid_load = 1'b1;
            state_d   = FULL;
         end else if (drain) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
         end
         FULL: begin
            main_d = skid_q;
            if (drain) begin
               main_load = 1'b1;
               skid_clr  = 1'b1;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // A squash drops everything, including a payload offered this cycle.
      if (flush) begin
         main_load = 1'b0;
         skid_load = 1'b0;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
         state_d   = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   pipe_entry_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load_i  (main_load),
      .clr_i   (main_clr),
      .d_i     (main_d),
      .q_o     (main_q),
      .valid_o (main_valid)
   );

   generate
      if (SKID) begin : g_skid
         logic in_ready_q;

         pipe_entry_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
            .clk     (clk),
            .reset   (reset),
            .load_i  (skid_load),
            .clr_i   (skid_clr),
            .d_i     (in_data),
            .q_o     (skid_q),
            .valid_o (skid_valid)
         );

         // Registered ready breaks the stall path back into the previous stage.
         always_ff @(posedge clk) begin
            if (reset)
               in_ready_q <= 1'b1;
            else
               in_ready_q <= (state_d != FULL);
         end

         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign skid_q     = RESET_VAL;
         assign skid_valid = 1'b0;
         assign in_ready   = !main_valid | out_ready;
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_data  = main_q;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid (SKID=1) and a single-entry (SKID=0) stage with the same inputs and
// checks both against a FIFO-level model, plus hand-computed directed expectations.
module tb_pipe_stage_reg;
   import cpu_pipe_pkg::*;

   localparam logic [7:0] RV1 = 8'hA5;
   localparam logic [7:0] RV0 = 8'h3C;

   logic       clk = 1'b0;
   logic       reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       s_in_ready, s_out_valid, n_in_ready, n_out_valid;
   logic [7:0] s_out_data, n_out_data;
   logic [1:0] s_occ, n_occ;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;
   bit log_en  = 1'b1;
   logic [7:0] out_log[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(8), .SKID(1'b1), .RESET_VAL(RV1)) dut_s (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .occupancy(s_occ)
   );

   pipe_stage_reg #(.WIDTH(8), .SKID(1'b0), .RESET_VAL(RV0)) dut_n (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
      .occupancy(n_occ)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: each stage is a FIFO of capacity 2 (skid) or 1; the visible data
   // when empty is the last payload that sat at the head.
   logic [7:0] mq_s[$], mq_n[$];
   logic [7:0] last_s = RV1, last_n = RV0;

   function automatic bit m_ready_s();
      return mq_s.size() != 2;
   endfunction
   function automatic bit m_ready_n();
      return (mq_n.size() == 0) || out_ready;
   endfunction

   always @(posedge clk) begin
      bit acc_s, acc_n, drn_s, drn_n;
      acc_s = in_valid && m_ready_s();
      acc_n = in_valid && m_ready_n();
      drn_s = (mq_s.size() != 0) && out_ready;
      drn_n = (mq_n.size() != 0) && out_ready;
      if (reset) begin
         mq_s.delete(); mq_n.delete();
         last_s = RV1;  last_n = RV0;
      end else if (flush) begin
         if (mq_s.size() != 0) last_s = mq_s[0];
         if (mq_n.size() != 0) last_n = mq_n[0];
         mq_s.delete(); mq_n.delete();
      end else begin
         if (drn_s) last_s = mq_s.pop_front();
         if (drn_n) last_n = mq_n.pop_front();
         if (acc_s) mq_s.push_back(in_data);
         if (acc_n) mq_n.push_back(in_data);
      end
      started = 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("s_out_valid", 32'(s_out_valid), 32'(mq_s.size() != 0));
         chk("s_occupancy", 32'(s_occ), 32'(mq_s.size()));
         chk("s_in_ready", 32'(s_in_ready), 32'(m_ready_s()));
         chk("s_out_data", 32'(s_out_data), 32'((mq_s.size() != 0) ? mq_s[0] : last_s));
         chk("n_out_valid", 32'(n_out_valid), 32'(mq_n.size() != 0));
         chk("n_occupancy", 32'(n_occ), 32'(mq_n.size()));
         chk("n_in_ready", 32'(n_in_ready), 32'(m_ready_n()));
         chk("n_out_data", 32'(n_out_data), 32'((mq_n.size() != 0) ? mq_n[0] : last_n));
         if (s_out_valid && out_ready && !reset && !flush) begin
            $display("[TB] t=%0t skid stage delivers %02h", $time, s_out_data);
            if (log_en) out_log.push_back(s_out_data);
         end
      end
   end

   // Apply inputs, let one edge consume them, return just after that edge.
   task automatic cyc(input logic rst, input logic fl, input logic iv,
                      input logic [7:0] d, input logic ordy);
      reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_log[7];
      exp_log = '{8'h11, 8'h22, 8'h33, 8'h0A, 8'h0B, 8'h0C, 8'h05};

      cyc(1, 0, 0, 8'h00, 0);
      cyc(1, 0, 0, 8'h00, 0);
      chk("rst_s_out_valid", 32'(s_out_valid), 32'd0);
      chk("rst_s_occ", 32'(s_occ), 32'd0);
      chk("rst_s_out_data", 32'(s_out_data), 32'hA5);
      chk("rst_s_in_ready", 32'(s_in_ready), 32'd1);
      chk("rst_n_out_data", 32'(n_out_data), 32'h3C);

      cyc(0, 0, 1, 8'h11, 1);
      chk("stream_11", 32'(s_out_data), 32'h11);
      cyc(0, 0, 1, 8'h22, 1);
      chk("stream_22", 32'(s_out_data), 32'h22);
      cyc(0, 0, 1, 8'h33, 1);
      chk("stream_33", 32'(s_out_data), 32'h33);
      chk("stream_occ", 32'(s_occ), 32'd1);
      cyc(0, 0, 0, 8'h00, 1);

      cyc(0, 0, 1, 8'h0A, 0);
      cyc(0, 0, 1, 8'h0B, 0);
      chk("bp_s_occ_full", 32'(s_occ), 32'd2);
      chk("bp_s_in_ready", 32'(s_in_ready), 32'd0);
      chk("bp_n_in_ready", 32'(n_in_ready), 32'd0);
      chk("bp_n_occ", 32'(n_occ), 32'd1);
      cyc(0, 0, 1, 8'h0C, 0);
      chk("bp_s_hold", 32'(s_out_data), 32'h0A);
      cyc(0, 0, 1, 8'h0C, 1);
      chk("bp_s_second", 32'(s_out_data), 32'h0B);
      chk("bp_n_replace", 32'(n_out_data), 32'h0C);
      cyc(0, 0, 1, 8'h0C, 1);
      chk("bp_s_third", 32'(s_out_data), 32'h0C);
      cyc(0, 0, 0, 8'h00, 1);

      cyc(0, 0, 1, 8'h01, 0);
      cyc(0, 0, 1, 8'h02, 0);
      cyc(0, 1, 1, 8'h0D, 0);
      chk("flush_s_occ", 32'(s_occ), 32'd0);
      chk("flush_s_out_valid", 32'(s_out_valid), 32'd0);
      chk("flush_s_data_kept", 32'(s_out_data), 32'h01);
      chk("flush_n_occ", 32'(n_occ), 32'd0);
      cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 0, 0, 8'h00, 1);

      cyc(0, 0, 1, 8'h05, 1);
      chk("n_load_05", 32'(n_out_data), 32'h05);
      cyc(0, 0, 0, 8'h00, 0);
      chk("n_ready_comb", 32'(n_in_ready), 32'd0);
      cyc(0, 0, 0, 8'h00, 1);

      cyc(0, 0, 1, 8'h06, 0);
      cyc(0, 0, 1, 8'h07, 0);
      cyc(1, 1, 1, 8'h0E, 0);
      chk("rstfull_s_occ", 32'(s_occ), 32'd0);
      chk("rstfull_s_out_data", 32'(s_out_data), 32'hA5);
      chk("rstfull_s_in_ready", 32'(s_in_ready), 32'd1);
      chk("rstfull_n_out_data", 32'(n_out_data), 32'h3C);
      cyc(0, 0, 0, 8'h00, 0);

      chk("log_count", 32'(out_log.size()), 32'd7);
      for (int i = 0; i < 7; i++)
         chk("log_order", 32'((i < out_log.size()) ? out_log[i] : 8'hXX), 32'(exp_log[i]));

      log_en = 1'b0;
      for (int i = 0; i < 80; i++)
         cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 0, 0, 8'h00, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
